// File: rtl/traffic_sensor_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_sensor_frontend_if
//  Description : Bundle of the per-approach sensor signals (N/S/E/W) running
//                between the intersection controller side and the sensor
//                front end.
//                master : drives the car pulses, light states and raw sirens,
//                         and receives the densities, ambulance requests and
//                         red-run flags.
//                slave  : the front end. It receives the inputs and drives
//                         the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface traffic_sensor_frontend_if;
    logic       car_in_n,  car_in_s,  car_in_e,  car_in_w;
    logic       car_out_n, car_out_s, car_out_e, car_out_w;
    logic [2:0] n_lights,  s_lights,  e_lights,  w_lights;
    logic       siren_n,   siren_s,   siren_e,   siren_w;
    logic [3:0] density_n, density_s, density_e, density_w;
    logic       amb_n,     amb_s,     amb_e,     amb_w;
    logic       red_run_n, red_run_s, red_run_e, red_run_w;

    modport master (
        output car_in_n,  car_in_s,  car_in_e,  car_in_w,
        output car_out_n, car_out_s, car_out_e, car_out_w,
        output n_lights,  s_lights,  e_lights,  w_lights,
        output siren_n,   siren_s,   siren_e,   siren_w,
        input  density_n, density_s, density_e, density_w,
        input  amb_n,     amb_s,     amb_e,     amb_w,
        input  red_run_n, red_run_s, red_run_e, red_run_w
    );

    modport slave (
        input  car_in_n,  car_in_s,  car_in_e,  car_in_w,
        input  car_out_n, car_out_s, car_out_e, car_out_w,
        input  n_lights,  s_lights,  e_lights,  w_lights,
        input  siren_n,   siren_s,   siren_e,   siren_w,
        output density_n, density_s, density_e, density_w,
        output amb_n,     amb_s,     amb_e,     amb_w,
        output red_run_n, red_run_s, red_run_e, red_run_w
    );
endinterface
`default_nettype wire

// File: rtl/traffic_sensor_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_sensor_frontend
//  Description : Per-approach vehicle queue counters with red-light-run
//                detection, and debounced ambulance siren qualification.
//                A shared grant arbiter allows at most one request at a time.
//                Its priority order is N > S > E > W.
//  Ports       : clk   - single clock, rising edge
//                rst_a - synchronous active-low reset
//                bus   - traffic_sensor_frontend_if.slave. It carries the car
//                        in/out pulses, light states and raw sirens in, and
//                        the densities, amb requests and red-run flags out.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_sensor_frontend #(
    parameter int DEB_CYCLES  = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_EMERG   = 255
) (
    input  wire logic               clk,
    input  wire logic               rst_a,
    traffic_sensor_frontend_if.slave bus
);
    localparam int         c_NUM          = 4;
    localparam logic [7:0] c_DEB          = 8'(DEB_CYCLES);
    localparam logic [7:0] c_HOLD         = 8'(HOLD_CYCLES);
    localparam logic [7:0] c_MAX          = 8'(MAX_EMERG);
    localparam logic [2:0] c_LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] c_LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMING  = 3'd1,
        S_PENDING = 3'd2,
        S_ACTIVE  = 3'd3,
        S_RELEASE = 3'd4,
        S_LOCKOUT = 3'd5
    } siren_state_t;

    // Index 0..3 = N, S, E, W throughout.
    logic [c_NUM-1:0] w_car_in, w_car_out, w_siren;
    logic [2:0]       w_lights  [c_NUM];
    logic [3:0]       w_density [c_NUM];
    logic [c_NUM-1:0] w_amb, w_red_run;
    logic [c_NUM-1:0] w_busy, w_eligible, w_grant;
    logic             w_grant_ok, w_taken;
    logic             r_busy_prev;

    assign w_car_in  = {bus.car_in_w,  bus.car_in_e,  bus.car_in_s,  bus.car_in_n};
    assign w_car_out = {bus.car_out_w, bus.car_out_e, bus.car_out_s, bus.car_out_n};
    assign w_siren   = {bus.siren_w,   bus.siren_e,   bus.siren_s,   bus.siren_n};
    assign w_lights[0] = bus.n_lights;
    assign w_lights[1] = bus.s_lights;
    assign w_lights[2] = bus.e_lights;
    assign w_lights[3] = bus.w_lights;

    assign bus.density_n = w_density[0];
    assign bus.density_s = w_density[1];
    assign bus.density_e = w_density[2];
    assign bus.density_w = w_density[3];
    assign bus.amb_n     = w_amb[0];
    assign bus.amb_s     = w_amb[1];
    assign bus.amb_e     = w_amb[2];
    assign bus.amb_w     = w_amb[3];
    assign bus.red_run_n = w_red_run[0];
    assign bus.red_run_s = w_red_run[1];
    assign bus.red_run_e = w_red_run[2];
    assign bus.red_run_w = w_red_run[3];

    // A new grant waits until nobody is in emergency now and nobody was in
    // emergency in the previous cycle. Because amb lags the state by one
    // edge, this leaves at least one all-low amb cycle between two requests.
    assign w_grant_ok = ~(|w_busy) & ~r_busy_prev;

    always_comb begin
        w_grant = '0;
        w_taken = 1'b0;
        for (int k = 0; k < c_NUM; k++) begin
            if (w_grant_ok && w_eligible[k] && !w_taken) begin
                w_grant[k] = 1'b1;
                w_taken    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_a) r_busy_prev <= 1'b0;
        else        r_busy_prev <= |w_busy;
    end

    for (genvar i = 0; i < c_NUM; i++) begin : g_approach
        siren_state_t r_state;
        logic [7:0]   r_deb_cnt, r_hold_cnt, r_emerg_cnt;
        logic [3:0]   r_queue, r_density;
        logic         r_amb, r_red_run;
        logic         w_is_red;

        // Any light code that is not exactly GREEN or YELLOW counts as RED.
        assign w_is_red      = (w_lights[i] != c_LIGHT_GREEN) && (w_lights[i] != c_LIGHT_YELLOW);
        assign w_busy[i]     = (r_state == S_ACTIVE) || (r_state == S_RELEASE);
        // A PENDING approach whose siren has just dropped goes to IDLE
        // instead of competing for the grant.
        assign w_eligible[i] = (r_state == S_PENDING) && w_siren[i];
        assign w_density[i]  = r_density;
        assign w_amb[i]      = r_amb;
        assign w_red_run[i]  = r_red_run;

        always_ff @(posedge clk) begin
            if (!rst_a) begin
                r_state     <= S_IDLE;
                r_deb_cnt   <= 8'd0;
                r_hold_cnt  <= 8'd0;
                r_emerg_cnt <= 8'd0;
                r_queue     <= 4'd0;
                r_density   <= 4'd0;
                r_amb       <= 1'b0;
                r_red_run   <= 1'b0;
            end else begin
                if (w_car_in[i] && !w_car_out[i]) begin
                    if (r_queue != 4'd15) r_queue <= r_queue + 4'd1;
                end else if (!w_car_in[i] && w_car_out[i]) begin
                    if (r_queue != 4'd0) r_queue <= r_queue - 4'd1;
                end
                r_density <= r_queue;
                r_red_run <= w_car_out[i] && w_is_red;
                r_amb     <= w_busy[i];

                case (r_state)
                    S_IDLE: begin
                        if (w_siren[i]) begin
                            r_state   <= S_ARMING;
                            r_deb_cnt <= 8'd1;
                        end
                    end
                    S_ARMING: begin
                        if (!w_siren[i]) begin
                            r_state <= S_IDLE;
                        end else if (r_deb_cnt + 8'd1 >= c_DEB) begin
                            r_state <= S_PENDING;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + 8'd1;
                        end
                    end
                    S_PENDING: begin
                        if (!w_siren[i]) begin
                            r_state <= S_IDLE;
                        end else if (w_grant[i]) begin
                            r_state     <= S_ACTIVE;
                            r_emerg_cnt <= 8'd1;
                        end
                    end
                    S_ACTIVE: begin
                        // The timeout check comes before the siren check.
                        // The count is of cycles spent in ACTIVE/RELEASE.
                        if (r_emerg_cnt >= c_MAX) begin
                            r_state <= S_LOCKOUT;
                        end else begin
                            r_emerg_cnt <= r_emerg_cnt + 8'd1;
                            if (!w_siren[i]) begin
                                r_state    <= S_RELEASE;
                                r_hold_cnt <= 8'd1;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (r_emerg_cnt >= c_MAX) begin
                            r_state <= S_LOCKOUT;
                        end else begin
                            r_emerg_cnt <= r_emerg_cnt + 8'd1;
                            if (w_siren[i]) begin
                                r_state <= S_ACTIVE;
                            end else if (r_hold_cnt + 8'd1 >= c_HOLD) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_hold_cnt <= r_hold_cnt + 8'd1;
                            end
                        end
                    end
                    S_LOCKOUT: begin
                        if (!w_siren[i]) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_frontend.sv
`timescale 1ns/1ps
`default_nettype none
module tb_traffic_sensor_frontend;
    localparam int DEB  = 3;
    localparam int HOLD = 8;
    localparam int MAXE = 255;

    logic clk = 1'b0;
    logic rst_a;
    logic [3:0] car_in, car_out, siren;   // index 0..3 = N,S,E,W
    logic [2:0] lights [4];

    traffic_sensor_frontend_if bus();

    traffic_sensor_frontend #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .MAX_EMERG(MAXE)
    ) dut (
        .clk(clk), .rst_a(rst_a), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.car_in_n  = car_in[0];  assign bus.car_in_s  = car_in[1];
    assign bus.car_in_e  = car_in[2];  assign bus.car_in_w  = car_in[3];
    assign bus.car_out_n = car_out[0]; assign bus.car_out_s = car_out[1];
    assign bus.car_out_e = car_out[2]; assign bus.car_out_w = car_out[3];
    assign bus.siren_n   = siren[0];   assign bus.siren_s   = siren[1];
    assign bus.siren_e   = siren[2];   assign bus.siren_w   = siren[3];
    assign bus.n_lights  = lights[0];  assign bus.s_lights  = lights[1];
    assign bus.e_lights  = lights[2];  assign bus.w_lights  = lights[3];

    int n_pass = 0, n_total = 0, n_fail = 0;

    // Reference model. Each approach is in one of three modes: waiting,
    // emergency or lockout. It keeps run lengths of siren high/low samples
    // and the number of cycles spent in emergency so far.
    int m_q[4], m_dens[4], m_red[4], m_amb[4];
    int m_mode[4];          // 0 waiting, 1 emergency, 2 lockout
    int m_hi[4], m_lo[4], m_busy[4];
    int m_prev_any;

    function automatic string nm(input int i);
        case (i) 0: return "n"; 1: return "s"; 2: return "e"; default: return "w"; endcase
    endfunction

    function automatic logic [3:0] obs_dens(input int i);
        case (i) 0: return bus.density_n; 1: return bus.density_s;
                 2: return bus.density_e; default: return bus.density_w; endcase
    endfunction

    function automatic logic [3:0] obs_amb();
        return {bus.amb_w, bus.amb_e, bus.amb_s, bus.amb_n};
    endfunction

    function automatic logic [3:0] obs_red();
        return {bus.red_run_w, bus.red_run_e, bus.red_run_s, bus.red_run_n};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int any_now, ok, granted, s, l;
        if (!rst_a) begin
            for (int i = 0; i < 4; i++) begin
                m_q[i] = 0; m_dens[i] = 0; m_red[i] = 0; m_amb[i] = 0;
                m_mode[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_busy[i] = 0;
            end
            m_prev_any = 0;
            return;
        end
        any_now = 0;
        for (int i = 0; i < 4; i++) if (m_mode[i] == 1) any_now = 1;
        ok = (any_now == 0 && m_prev_any == 0);
        granted = 0;
        for (int i = 0; i < 4; i++) begin
            s = int'(siren[i]);
            m_amb[i] = (m_mode[i] == 1);
            if (m_mode[i] == 0) begin
                // Qualified means DEB high samples already seen. The grant
                // goes to the first qualified approach in N,S,E,W order
                // whose siren is still high.
                if (s == 1 && m_hi[i] >= DEB && ok == 1 && granted == 0) begin
                    m_mode[i] = 1; m_busy[i] = 0; m_lo[i] = 0; granted = 1;
                    m_hi[i] = 0;
                end else begin
                    m_hi[i] = (s == 1) ? m_hi[i] + 1 : 0;
                end
            end else if (m_mode[i] == 1) begin
                m_busy[i]++;
                m_hi[i] = 0;
                if (m_busy[i] >= MAXE)   m_mode[i] = 2;
                else if (s == 0) begin
                    m_lo[i]++;
                    if (m_lo[i] >= HOLD) m_mode[i] = 0;
                end else m_lo[i] = 0;
            end else begin
                m_hi[i] = 0;
                if (s == 0) m_mode[i] = 0;
            end
            m_dens[i] = m_q[i];
            if (car_in[i] && !car_out[i])      m_q[i] = (m_q[i] < 15) ? m_q[i] + 1 : 15;
            else if (!car_in[i] && car_out[i]) m_q[i] = (m_q[i] > 0) ? m_q[i] - 1 : 0;
            l = int'(lights[i]);
            m_red[i] = (car_out[i] && l != 1 && l != 2) ? 1 : 0;
        end
        m_prev_any = any_now;
    endtask

    task automatic step();
        logic [3:0] a, r;
        @(posedge clk);
        model_edge();
        #1;
        a = obs_amb();
        r = obs_red();
        for (int i = 0; i < 4; i++) begin
            chk({"density_", nm(i)}, int'(obs_dens(i)), m_dens[i]);
            chk({"amb_", nm(i)},     int'(a[i]),        m_amb[i]);
            chk({"red_run_", nm(i)}, int'(r[i]),        m_red[i]);
        end
        chk("amb_at_most_one", int'($countones(a) <= 1), 1);
    endtask

    task automatic quiet();
        car_in = '0; car_out = '0;
    endtask

    initial begin
        int amb_w_high, gap, saw_n, saw_e_after_gap, low_run;
        rst_a = 1'b0; siren = 4'hF; car_in = 4'hF; car_out = 4'h0;
        for (int i = 0; i < 4; i++) lights[i] = 3'b100;

        // Reset with active inputs: all of them must be ignored.
        repeat (3) step();
        rst_a = 1'b1; siren = '0; quiet();
        step();

        // Twenty north arrivals on RED saturate at 15.
        for (int k = 0; k < 20; k++) begin
            car_in[0] = 1'b1; step(); quiet(); step();
        end
        step();
        chk("sat_density_n", int'(bus.density_n), 15);

        // East: load 2, depart on GREEN three times, then in and out together.
        lights[2] = 3'b001;
        repeat (2) begin car_in[2] = 1'b1; step(); quiet(); step(); end
        repeat (3) begin car_out[2] = 1'b1; step(); quiet(); step(); end
        car_in[2] = 1'b1; car_out[2] = 1'b1; step(); quiet(); step(); step();
        chk("floor_density_e", int'(bus.density_e), 0);

        // West: departures on RED and on the invalid code 111.
        repeat (3) begin car_in[3] = 1'b1; step(); quiet(); step(); end
        lights[3] = 3'b100; car_out[3] = 1'b1; step(); quiet();
        chk("red_run_w_on_100", int'(bus.red_run_w), 1);
        step();
        lights[3] = 3'b111; car_out[3] = 1'b1; step(); quiet();
        chk("red_run_w_on_111", int'(bus.red_run_w), 1);
        step();
        chk("red_run_w_one_cycle", int'(bus.red_run_w), 0);

        // South siren: too short, then qualifying, then release.
        siren[1] = 1'b1; repeat (2) step();
        siren[1] = 1'b0; repeat (6) step();
        siren[1] = 1'b1; repeat (4) step();
        chk("amb_s_not_before_4", int'(bus.amb_s), 0);
        step();
        chk("amb_s_latency", int'(bus.amb_s), 1);
        repeat (5) step();
        siren[1] = 1'b0; repeat (HOLD + 2) step();
        chk("amb_s_released", int'(bus.amb_s), 0);
        repeat (3) step();

        // North and east together: N wins, then a gap, then E.
        siren[0] = 1'b1; siren[2] = 1'b1;
        saw_n = 0; gap = 0; saw_e_after_gap = 0; low_run = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 15) siren[0] = 1'b0;
            step();
            if (bus.amb_n) saw_n = 1;
            if (saw_n == 1 && obs_amb() == 4'b0000) low_run++;
            if (bus.amb_e && saw_n == 1) begin
                if (low_run > gap) gap = low_run;
                saw_e_after_gap = 1;
            end
        end
        chk("arb_n_first_then_e", saw_e_after_gap, 1);
        chk("arb_gap_at_least_1", int'(gap >= 1), 1);
        siren[2] = 1'b0; repeat (HOLD + 3) step();

        // West held for 300 cycles: timeout, lockout, re-qualify.
        siren[3] = 1'b1; amb_w_high = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (bus.amb_w) amb_w_high++;
        end
        chk("amb_w_timeout_cycles", amb_w_high, MAXE);
        chk("amb_w_lockout_low", int'(bus.amb_w), 0);
        siren[3] = 1'b0; step();
        siren[3] = 1'b1; repeat (5) step();
        chk("amb_w_requalified", int'(bus.amb_w), 1);
        siren[3] = 1'b0; repeat (HOLD + 3) step();

        // Reset in the middle of an emergency.
        siren[0] = 1'b1; repeat (8) step();
        rst_a = 1'b0; step();
        chk("amb_n_reset_drop", int'(bus.amb_n), 0);
        rst_a = 1'b1; repeat (6) step();

        // Randomized traffic with sticky sirens and occasional resets.
        siren = '0;
        for (int k = 0; k < 2000; k++) begin
            rst_a = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < 4; i++) begin
                car_in[i]  = ($urandom_range(0, 2) == 0);
                car_out[i] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 11) == 0) siren[i] = ~siren[i];
                if ($urandom_range(0, 7) == 0) lights[i] = 3'($urandom_range(0, 7));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
